// File: rtl/seven_seg_scanner_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the seven-segment scanner slice:
//   state_e      - scanner FSM states (IDLE, ON, GAP)
//   SEG_OFF      - active-low segment word with every segment dark
//   AN_OFF       - active-low anode word with every digit dark
//   seg7_decode  - hex code to active-high gfedcba segment table
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Hex digit to active-high segment pattern, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] seg7_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner_if
// Bundles the scanner's data inputs and display outputs.
//   enable      - scan enable (low = display dark)
//   digits_in   - four 4-bit digit codes, nibble k = digit k
//   blank_in    - per-digit blank request
//   dp_in       - per-digit decimal point request
//   seg_n/dp_n  - active-low segment and decimal-point lines
//   an_n        - active-low anodes, bit k = digit k
//   cur_digit   - digit slot being scanned
//   frame_start - one-cycle pulse at the start of each frame
// master: the producer of digit data (drives inputs, observes outputs)
// slave : the scanner itself
// -----------------------------------------------------------------------------
interface seven_seg_scanner_if;

    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  blank_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic [1:0]  cur_digit;
    logic        frame_start;

    modport master (
        output enable, digits_in, blank_in, dp_in,
        input  seg_n, dp_n, an_n, cur_digit, frame_start
    );

    modport slave (
        input  enable, digits_in, blank_in, dp_in,
        output seg_n, dp_n, an_n, cur_digit, frame_start
    );

endinterface

// File: rtl/seven_seg_scanner_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational hex to seven-segment decoder.
//   code  - 4-bit hex digit
//   seg_n - active-low segments, bit 0 = a ... bit 6 = g
// -----------------------------------------------------------------------------
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    // Invert the active-high table entry for the common-anode display.
    always_comb begin
        seg_n = ~seg7_decode(code);
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplexed 4-digit seven-segment driver. Each digit is lit for
// ON_CYCLES clocks followed by GAP_CYCLES clocks with every anode off.
// Digit data is snapshotted on entry to digit 0 so a mid-frame update of the
// inputs cannot tear the displayed number.
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - seven_seg_scanner_if slave port (data in, display out)
// All outputs are registered; they are computed from the next-state values so
// that the edge entering a slot already presents that slot's drive.
// -----------------------------------------------------------------------------
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int ON_CYCLES  = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    seven_seg_scanner_if.slave    bus
);

    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    // With no gap the GAP state is never entered; the value is unused.
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : CNT_ZERO;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      snap_digits_q, snap_digits_d;
    logic [3:0]       snap_blank_q, snap_blank_d;
    logic [3:0]       snap_dp_q, snap_dp_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;
    logic             frame_start_q, frame_start_d;

    logic             start_frame_s;
    logic [3:0]       dec_code_s;
    logic [6:0]       dec_seg_n_s;

    // FSM next state, slot counter, digit index and frame snapshot.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        digit_d       = digit_q;
        start_frame_s = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
            digit_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = ON;
                    cnt_d         = CNT_ZERO;
                    digit_d       = 2'd0;
                    start_frame_s = 1'b1;
                end
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        cnt_d = CNT_ZERO;
                        if (GAP_CYCLES == 0) begin
                            // No blanking gap: step straight to the next digit.
                            state_d       = ON;
                            digit_d       = digit_q + 2'd1;
                            start_frame_s = (digit_q == 2'd3);
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d       = ON;
                        cnt_d         = CNT_ZERO;
                        digit_d       = digit_q + 2'd1;
                        start_frame_s = (digit_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                    digit_d = 2'd0;
                end
            endcase
        end

        if (start_frame_s) begin
            snap_digits_d = bus.digits_in;
            snap_blank_d  = bus.blank_in;
            snap_dp_d     = bus.dp_in;
        end else begin
            snap_digits_d = snap_digits_q;
            snap_blank_d  = snap_blank_q;
            snap_dp_d     = snap_dp_q;
        end

        // Decode the nibble of the slot being entered, from the snapshot
        // as it will stand after this edge.
        dec_code_s = snap_digits_d[{digit_d, 2'b00} +: 4];
    end

    seg7_decoder u_decoder (
        .code  (dec_code_s),
        .seg_n (dec_seg_n_s)
    );

    // Display drive for the next cycle; a blanked digit stays fully dark.
    always_comb begin
        seg_d         = SEG_OFF;
        an_d          = AN_OFF;
        dp_d          = 1'b1;
        frame_start_d = start_frame_s;
        if (state_d == ON) begin
            if (snap_blank_d[digit_d]) begin
                seg_d = SEG_OFF;
                an_d  = AN_OFF;
                dp_d  = 1'b1;
            end else begin
                seg_d = dec_seg_n_s;
                an_d  = ~(4'b0001 << digit_d);
                dp_d  = ~snap_dp_d[digit_d];
            end
        end else begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
            dp_d  = 1'b1;
        end
    end

    // State, counter, snapshot and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_ZERO;
            digit_q       <= 2'd0;
            snap_digits_q <= 16'h0000;
            snap_blank_q  <= 4'h0;
            snap_dp_q     <= 4'h0;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            snap_digits_q <= snap_digits_d;
            snap_blank_q  <= snap_blank_d;
            snap_dp_q     <= snap_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.seg_n       = seg_q;
    assign bus.dp_n        = dp_q;
    assign bus.an_n        = an_q;
    assign bus.cur_digit   = digit_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
// Self-checking bench for seven_seg_scanner. Two instances: ON=4/GAP=1 and
// ON=4/GAP=0. Expected per-cycle display words are pushed to a scoreboard
// queue when stimulus is applied and popped one per clock as the DUT runs.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int ON_C  = 4;
    localparam int GAP_C = 1;

    localparam logic [6:0] SEG_HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } obs_t;

    typedef struct packed {
        obs_t       val;
        obs_t       mask;
        logic [1:0] cd;
        logic       cd_chk;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    exp_t sb_q[$];

    seven_seg_scanner_if ifc1 ();
    seven_seg_scanner_if ifc2 ();

    seven_seg_scanner #(.ON_CYCLES(ON_C), .GAP_CYCLES(GAP_C)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc1)
    );

    seven_seg_scanner #(.ON_CYCLES(ON_C), .GAP_CYCLES(0)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dark(input int n, input logic cd_chk);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.val    = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
            e.mask   = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b1};
            e.cd     = 2'd0;
            e.cd_chk = cd_chk;
            sb_q.push_back(e);
        end
    endtask

    task automatic push_frame(input logic [15:0] dg, input logic [3:0] bl,
                              input logic [3:0] dp, input int gap);
        exp_t       e;
        logic [3:0] code;
        for (int k = 0; k < 4; k++) begin
            code = dg[k*4 +: 4];
            for (int c = 0; c < ON_C; c++) begin
                e.val.an  = bl[k] ? 4'hF : ~(4'b0001 << k);
                e.val.seg = ~SEG_HI[code];
                e.val.dp  = ~dp[k];
                e.val.fs  = (k == 0) && (c == 0);
                // A blanked slot only promises dark anodes.
                e.mask    = bl[k] ? '{an: 4'hF, seg: 7'h00, dp: 1'b0, fs: 1'b1}
                                  : '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b1};
                e.cd      = k[1:0];
                e.cd_chk  = 1'b1;
                sb_q.push_back(e);
            end
            push_dark(gap, 1'b0);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        obs_t o;
        reset = 1'b1;
        ifc1.enable = 1'b1;
        ifc1.digits_in = 16'h1234;
        push_dark(5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (sb_q.size() == 0) begin
                n_miss++;
                $display("FAIL reset: scoreboard empty at cycle %0d", i);
            end else begin
                e = sb_q.pop_front();
                o = '{an: ifc1.an_n, seg: ifc1.seg_n, dp: ifc1.dp_n, fs: ifc1.frame_start};
                if ((o & e.mask) !== (e.val & e.mask)) begin
                    n_miss++;
                    $display("FAIL reset cyc %0d: got an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                             i, o.an, o.seg, o.dp, o.fs, e.val.an, e.val.seg, e.val.dp, e.val.fs);
                end
                if (e.cd_chk) begin
                    n_vec++;
                    if (ifc1.cur_digit !== e.cd) begin
                        n_miss++;
                        $display("FAIL reset cur_digit cyc %0d: got %0d want %0d", i, ifc1.cur_digit, e.cd);
                    end
                end
            end
        end
        reset = 1'b0;
        ifc1.enable = 1'b0;
        step();
    endtask

    task automatic test_scan();
        exp_t e;
        obs_t o;
        ifc1.digits_in = 16'h1234;
        ifc1.blank_in  = 4'h0;
        ifc1.dp_in     = 4'h0;
        ifc1.enable    = 1'b1;
        push_frame(16'h1234, 4'h0, 4'h0, GAP_C);
        push_frame(16'h1234, 4'h0, 4'h0, GAP_C);
        for (int i = 0; i < 40; i++) begin
            step();
            n_vec++;
            if (sb_q.size() == 0) begin
                n_miss++;
                $display("FAIL scan: scoreboard empty at cycle %0d", i);
            end else begin
                e = sb_q.pop_front();
                o = '{an: ifc1.an_n, seg: ifc1.seg_n, dp: ifc1.dp_n, fs: ifc1.frame_start};
                if ((o & e.mask) !== (e.val & e.mask)) begin
                    n_miss++;
                    $display("FAIL scan cyc %0d: got an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                             i, o.an, o.seg, o.dp, o.fs, e.val.an, e.val.seg, e.val.dp, e.val.fs);
                end
                if (e.cd_chk) begin
                    n_vec++;
                    if (ifc1.cur_digit !== e.cd) begin
                        n_miss++;
                        $display("FAIL scan cur_digit cyc %0d: got %0d want %0d", i, ifc1.cur_digit, e.cd);
                    end
                end
            end
        end
        ifc1.enable = 1'b0;
        step();
    endtask

    task automatic test_tearing();
        exp_t e;
        obs_t o;
        ifc1.digits_in = 16'h1234;
        ifc1.enable    = 1'b1;
        push_frame(16'h1234, 4'h0, 4'h0, GAP_C);
        push_frame(16'h5678, 4'h0, 4'h0, GAP_C);
        for (int i = 0; i < 40; i++) begin
            step();
            n_vec++;
            if (sb_q.size() == 0) begin
                n_miss++;
                $display("FAIL tearing: scoreboard empty at cycle %0d", i);
            end else begin
                e = sb_q.pop_front();
                o = '{an: ifc1.an_n, seg: ifc1.seg_n, dp: ifc1.dp_n, fs: ifc1.frame_start};
                if ((o & e.mask) !== (e.val & e.mask)) begin
                    n_miss++;
                    $display("FAIL tearing cyc %0d: got an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                             i, o.an, o.seg, o.dp, o.fs, e.val.an, e.val.seg, e.val.dp, e.val.fs);
                end
            end
            // Cycle 6 is inside the digit-1 ON slot of the first frame.
            if (i == 6) ifc1.digits_in = 16'h5678;
        end
        ifc1.enable = 1'b0;
        step();
    endtask

    task automatic test_blank_dp();
        exp_t e;
        obs_t o;
        ifc1.digits_in = 16'h0F0A;
        ifc1.blank_in  = 4'b1000;
        ifc1.dp_in     = 4'b0001;
        ifc1.enable    = 1'b1;
        push_frame(16'h0F0A, 4'b1000, 4'b0001, GAP_C);
        push_frame(16'h0F0A, 4'b1000, 4'b0001, GAP_C);
        for (int i = 0; i < 40; i++) begin
            step();
            n_vec++;
            if (sb_q.size() == 0) begin
                n_miss++;
                $display("FAIL blank_dp: scoreboard empty at cycle %0d", i);
            end else begin
                e = sb_q.pop_front();
                o = '{an: ifc1.an_n, seg: ifc1.seg_n, dp: ifc1.dp_n, fs: ifc1.frame_start};
                if ((o & e.mask) !== (e.val & e.mask)) begin
                    n_miss++;
                    $display("FAIL blank_dp cyc %0d: got an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                             i, o.an, o.seg, o.dp, o.fs, e.val.an, e.val.seg, e.val.dp, e.val.fs);
                end
            end
        end
        ifc1.enable   = 1'b0;
        ifc1.blank_in = 4'h0;
        ifc1.dp_in    = 4'h0;
        step();
    endtask

    task automatic test_enable_drop();
        exp_t e;
        obs_t o;
        ifc1.digits_in = 16'h1234;
        ifc1.enable    = 1'b1;
        push_frame(16'h1234, 4'h0, 4'h0, GAP_C);
        // Keep only cycles 0..11: enable falls during the digit-2 slot.
        for (int k = 0; k < 8; k++) void'(sb_q.pop_back());
        push_dark(1, 1'b0);
        push_frame(16'h9999, 4'h0, 4'h0, GAP_C);
        for (int i = 0; i < 33; i++) begin
            step();
            n_vec++;
            if (sb_q.size() == 0) begin
                n_miss++;
                $display("FAIL enable_drop: scoreboard empty at cycle %0d", i);
            end else begin
                e = sb_q.pop_front();
                o = '{an: ifc1.an_n, seg: ifc1.seg_n, dp: ifc1.dp_n, fs: ifc1.frame_start};
                if ((o & e.mask) !== (e.val & e.mask)) begin
                    n_miss++;
                    $display("FAIL enable_drop cyc %0d: got an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                             i, o.an, o.seg, o.dp, o.fs, e.val.an, e.val.seg, e.val.dp, e.val.fs);
                end
                if (e.cd_chk) begin
                    n_vec++;
                    if (ifc1.cur_digit !== e.cd) begin
                        n_miss++;
                        $display("FAIL enable_drop cur_digit cyc %0d: got %0d want %0d", i, ifc1.cur_digit, e.cd);
                    end
                end
            end
            if (i == 11) ifc1.enable = 1'b0;
            if (i == 12) begin
                ifc1.enable    = 1'b1;
                ifc1.digits_in = 16'h9999;
            end
        end
        ifc1.enable = 1'b0;
        step();
    endtask

    task automatic test_gap0();
        exp_t e;
        obs_t o;
        ifc2.digits_in = 16'h1234;
        ifc2.blank_in  = 4'h0;
        ifc2.dp_in     = 4'h0;
        ifc2.enable    = 1'b1;
        push_frame(16'h1234, 4'h0, 4'h0, 0);
        push_frame(16'h1234, 4'h0, 4'h0, 0);
        for (int i = 0; i < 32; i++) begin
            step();
            n_vec++;
            if (sb_q.size() == 0) begin
                n_miss++;
                $display("FAIL gap0: scoreboard empty at cycle %0d", i);
            end else begin
                e = sb_q.pop_front();
                o = '{an: ifc2.an_n, seg: ifc2.seg_n, dp: ifc2.dp_n, fs: ifc2.frame_start};
                if ((o & e.mask) !== (e.val & e.mask)) begin
                    n_miss++;
                    $display("FAIL gap0 cyc %0d: got an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                             i, o.an, o.seg, o.dp, o.fs, e.val.an, e.val.seg, e.val.dp, e.val.fs);
                end
                if (e.cd_chk) begin
                    n_vec++;
                    if (ifc2.cur_digit !== e.cd) begin
                        n_miss++;
                        $display("FAIL gap0 cur_digit cyc %0d: got %0d want %0d", i, ifc2.cur_digit, e.cd);
                    end
                end
            end
        end
        ifc2.enable = 1'b0;
        step();
    endtask

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        reset          = 1'b1;
        ifc1.enable    = 1'b1;
        ifc1.digits_in = 16'h0000;
        ifc1.blank_in  = 4'h0;
        ifc1.dp_in     = 4'h0;
        ifc2.enable    = 1'b0;
        ifc2.digits_in = 16'h0000;
        ifc2.blank_in  = 4'h0;
        ifc2.dp_in     = 4'h0;

        test_reset();
        test_scan();
        test_tearing();
        test_blank_dp();
        test_enable_drop();
        test_gap0();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed 4-digit seven-segment display driver. It is the consuming end of the digit-window path: the scroller writes 4-bit digit codes, and this block reads them, decodes them and scans them onto shared segment lines. Inputs are snapshotted once per frame so a scroll event mid-frame cannot tear the displayed number. A programmable blanking gap between digits suppresses ghosting.

## Interface
- `ON_CYCLES`, default 50000: clocks each digit's anode is on; must be ≥1.
- `GAP_CYCLES`, default 500: clocks with all anodes off after each digit; 0 allowed, meaning no gap.
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: scan enable; low holds the display dark.
- `digits_in`, in, 16: nibble k is digit k; digit 0 is rightmost; codes 0–F are hex.
- `blank_in`, in, 4: bit k=1 keeps digit k dark while its timing slot still elapses.
- `dp_in`, in, 4: bit k=1 lights the decimal point of digit k.
- `seg_n`, out, 7: segments, active-low; bit 0=a … bit 6=g.
- `dp_n`, out, 1: decimal point, active-low.
- `an_n`, out, 4: anodes, active-low; bit k is digit k.
- `cur_digit`, out, 2: index of the digit slot currently being scanned.
- `frame_start`, out, 1: one-cycle pulse on entry to digit 0 ON.

## Operation
- States:
  - IDLE: display dark.
  - ON: digit `cur_digit` driven.
  - GAP: all anodes off.
- Transitions:
  - IDLE→ON(digit 0) when `enable`=1.
  - ON→GAP after ON_CYCLES clocks. If GAP_CYCLES=0, go directly to ON of the next digit.
  - GAP→ON(next digit) after GAP_CYCLES clocks.
  - The digit index wraps 3→0. Entering ON(0) from IDLE or from the wrap starts a new frame.
- Any state→IDLE on the first edge where `enable`=0.
- Snapshot: on every entry to ON(0), capture `digits_in`, `blank_in` and `dp_in` into frame registers. All four digits of that frame use the snapshot. Input changes mid-frame appear only from the next frame.
- Decode, as active-high gfedcba before inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Output `seg_n` is the inverse of the decoded pattern.
- In ON, `an_n` has only bit `cur_digit` low, unless that digit's snapshot blank bit is set, in which case `an_n`=1111.
- In GAP and IDLE: `an_n`=1111, `seg_n`=7F, `dp_n`=1.
- The slot counter is $clog2(max(ON_CYCLES,GAP_CYCLES)+1) bits wide. It counts 0…N-1 and reloads to 0 on every state change.

## Timing
- All outputs are registered and change only on rising `clk`.
- Reset values: `seg_n`=7F, `dp_n`=1, `an_n`=1111, `cur_digit`=0, `frame_start`=0, state IDLE, counter 0, snapshot registers 0.
- `reset` overrides `enable`. Reset mid-frame gives dark outputs on the same edge.
- Enable latency: `enable`=1 sampled at edge t moves the state to ON(0) at edge t. At that same edge:
  - `an_n`=1110;
  - segments decode `digits_in[3:0]` as sampled at t;
  - `frame_start`=1 for exactly that cycle.
- Each ON slot is exactly ON_CYCLES cycles and each GAP slot exactly GAP_CYCLES cycles. The frame period is exactly 4·(ON_CYCLES+GAP_CYCLES) cycles, independent of blanking.
- Disable latency: `enable`=0 sampled at edge t gives dark outputs from edge t.
- Re-enable always restarts at digit 0 with a fresh snapshot and a `frame_start` pulse.
- `frame_start` is never asserted in GAP or IDLE, or twice within one frame.

## Structure
- Package `seg7_pkg` holds:
  - the state enum (`IDLE`, `ON`, `GAP`);
  - the constants `SEG_OFF`=7'h7F and `AN_OFF`=4'hF;
  - the hex→segment decode table.
- Sub-module `seg7_decoder`: combinational, 4-bit code in, 7-bit active-low segments out. The scanner instantiates it once, fed from the snapshot nibble selected by the next digit index.
- The scanner contains the FSM, the slot counter, the snapshot registers and the output registers.

## Test plan
All scenarios use ON_CYCLES=4 and GAP_CYCLES=1.
- Reset held with `enable`=1 → `an_n`=F, `seg_n`=7F, `dp_n`=1, `frame_start`=0 every cycle.
- `digits_in`=0x1234, all enabled:
  - → `an_n` sequence 1110×4, F×1, 1101×4, F×1, 1011×4, F×1, 0111×4, F×1;
  - → `seg_n` 19, 30, 24, 79 in the respective ON slots;
  - → `frame_start` every 20 cycles.
- Tearing check: change `digits_in` 0x1234→0x5678 during digit-1 ON → the rest of that frame still shows 3,2,1; the next frame shows 8 (`seg_n`=00) in digit 0.
- `blank_in`=1000, `dp_in`=0001, digits 0x0F0A:
  - → digit 3 slot is `an_n`=F for 4 cycles;
  - → digit 0 shows A (`seg_n`=08) with `dp_n`=0;
  - → the frame is still 20 cycles.
- `enable` dropped mid digit 2 → dark on that edge. Re-assert → ON(0) with `frame_start`=1 on the same edge.
- GAP_CYCLES=0 build → no all-off cycles; the frame is 16 cycles; anodes rotate 1110, 1101, 1011, 0111.
